rib_bus: RTL and testbench

RIB_BUS -- requirements
Module: rib_bus

---
 rtl/rib_bus.sv | 103 ++++++++++
 tb/tb_rib_bus.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rib_bus.sv
// rib_bus: two-master (core m0, loader m1) to four-slave router with grant FSM and sticky decode error.
// Ports: m0_* core read/write channels; m1_* loader channel with m1_gnt_o; s0..s3_* slave address,
// write data, write strobe and read data; rib_hold_flag_o freezes the core; err_o/err_addr_o/err_clr_i
// report the first decode error.
module rib_bus #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SLV_SEL_HI = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_rd_req_i,
  input  logic [ADDR_W-1:0] m0_rd_addr_i,
  output logic [DATA_W-1:0] m0_rd_data_o,
  input  logic              m0_wr_req_i,
  input  logic              m0_wr_en_i,
  input  logic [ADDR_W-1:0] m0_wr_addr_i,
  input  logic [DATA_W-1:0] m0_wr_data_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_gnt_o,
  output logic [ADDR_W-1:0] s0_addr_o,
  output logic [DATA_W-1:0] s0_wdata_o,
  output logic              s0_we_o,
  input  logic [DATA_W-1:0] s0_rdata_i,
  output logic [ADDR_W-1:0] s1_addr_o,
  output logic [DATA_W-1:0] s1_wdata_o,
  output logic              s1_we_o,
  input  logic [DATA_W-1:0] s1_rdata_i,
  output logic [ADDR_W-1:0] s2_addr_o,
  output logic [DATA_W-1:0] s2_wdata_o,
  output logic              s2_we_o,
  input  logic [DATA_W-1:0] s2_rdata_i,
  output logic [ADDR_W-1:0] s3_addr_o,
  output logic [DATA_W-1:0] s3_wdata_o,
  output logic              s3_we_o,
  input  logic [DATA_W-1:0] s3_rdata_i,
  output logic              rib_hold_flag_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  input  logic              err_clr_i
);
  typedef enum logic {IDLE, M1_GNT} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr [4];
  logic [DATA_W-1:0] wdata [4];
  logic [DATA_W-1:0] rdata [4];
  logic [3:0] we;
  logic [3:0] sel_r, sel_w, sel_m;
  logic m1_mode, rd_ok, err_hit, err_q, err_d;
  logic [ADDR_W-1:0] err_a, err_addr_q, err_addr_d;
  assign sel_r = m0_rd_addr_i[SLV_SEL_HI -: 4];
  assign sel_w = m0_wr_addr_i[SLV_SEL_HI -: 4];
  assign sel_m = m1_addr_i[SLV_SEL_HI -: 4];
  assign m1_mode = state_q == M1_GNT;
  assign rdata = '{s0_rdata_i, s1_rdata_i, s2_rdata_i, s3_rdata_i};
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr[k] = '0;
      wdata[k] = '0;
      we[k] = 1'b0;
      if (m1_mode) begin
        if (m1_req_i && sel_m == 4'(k)) begin
          addr[k] = m1_addr_i;
          wdata[k] = m1_wdata_i;
          we[k] = m1_we_i & ~rst;
        end
      end else if (m0_wr_req_i && sel_w == 4'(k)) begin
        addr[k] = m0_wr_addr_i;
        wdata[k] = m0_wr_data_i;
        we[k] = m0_wr_en_i;
      end else if (m0_rd_req_i && sel_r == 4'(k)) begin
        addr[k] = m0_rd_addr_i;
      end
    end
  end
  // A read that collides with a write to the same slave loses the slave port and returns 0.
  assign rd_ok = ~m1_mode & m0_rd_req_i & (sel_r < 4'd4) & ~(m0_wr_req_i & (sel_w == sel_r));
  assign m0_rd_data_o = rd_ok ? rdata[sel_r[1:0]] : '0;
  assign m1_rdata_o = (m1_mode & m1_req_i & (sel_m < 4'd4)) ? rdata[sel_m[1:0]] : '0;
  assign err_hit = m1_mode ? (m1_req_i & (sel_m > 4'd3))
                           : (m0_wr_req_i & (sel_w > 4'd3)) | (m0_rd_req_i & (sel_r > 4'd3));
  assign err_a = m1_mode ? m1_addr_i : (m0_wr_req_i & (sel_w > 4'd3)) ? m0_wr_addr_i : m0_rd_addr_i;
  assign state_d = (m1_req_i & ~rst) ? M1_GNT : IDLE;
  assign err_d = rst ? 1'b0 : err_hit ? 1'b1 : err_clr_i ? 1'b0 : err_q;
  // The first error address is kept until a clear; an error in the clearing cycle re-captures.
  assign err_addr_d = rst ? '0 : (err_hit & (~err_q | err_clr_i)) ? err_a : err_addr_q;
  always_ff @(posedge clk) begin
    state_q <= state_d;
    err_q <= err_d;
    err_addr_q <= err_addr_d;
  end
  assign m1_gnt_o = m1_mode;
  assign rib_hold_flag_o = m1_mode | m1_req_i;
  assign err_o = err_q;
  assign err_addr_o = err_addr_q;
  assign {s0_addr_o, s1_addr_o, s2_addr_o, s3_addr_o} = {addr[0], addr[1], addr[2], addr[3]};
  assign {s0_wdata_o, s1_wdata_o, s2_wdata_o, s3_wdata_o} = {wdata[0], wdata[1], wdata[2], wdata[3]};
  assign {s0_we_o, s1_we_o, s2_we_o, s3_we_o} = {we[0], we[1], we[2], we[3]};
endmodule

// File: tb/tb_rib_bus.sv
// tb_rib_bus: directed and randomized checks of rib_bus against a cycle-level ownership/decode model.
module tb_rib_bus;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_rd_req = 1'b0, m0_wr_req = 1'b0, m0_wr_en = 1'b0;
  logic [31:0] m0_rd_addr = '0, m0_wr_addr = '0, m0_wr_data = '0, m0_rd_data;
  logic m1_req = 1'b0, m1_we = 1'b0, m1_gnt;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
  logic [31:0] sa [4];
  logic [31:0] sw [4];
  logic swe [4];
  logic [31:0] sd [4];
  logic hold, err, err_clr = 1'b0;
  logic [31:0] err_addr;
  int checks = 0, errors = 0;
  bit owner, m_err;
  logic [31:0] m_erra;
  logic [31:0] ea [4];
  logic [31:0] ew [4];
  logic ewe [4];
  logic [31:0] e_rd0, e_rd1, e_erra;
  bit e_err;
  always #5 clk = ~clk;
  rib_bus dut (
    .clk(clk), .rst(rst),
    .m0_rd_req_i(m0_rd_req), .m0_rd_addr_i(m0_rd_addr), .m0_rd_data_o(m0_rd_data),
    .m0_wr_req_i(m0_wr_req), .m0_wr_en_i(m0_wr_en), .m0_wr_addr_i(m0_wr_addr), .m0_wr_data_i(m0_wr_data),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata), .m1_gnt_o(m1_gnt),
    .s0_addr_o(sa[0]), .s0_wdata_o(sw[0]), .s0_we_o(swe[0]), .s0_rdata_i(sd[0]),
    .s1_addr_o(sa[1]), .s1_wdata_o(sw[1]), .s1_we_o(swe[1]), .s1_rdata_i(sd[1]),
    .s2_addr_o(sa[2]), .s2_wdata_o(sw[2]), .s2_we_o(swe[2]), .s2_rdata_i(sd[2]),
    .s3_addr_o(sa[3]), .s3_wdata_o(sw[3]), .s3_we_o(swe[3]), .s3_rdata_i(sd[3]),
    .rib_hold_flag_o(hold), .err_o(err), .err_addr_o(err_addr), .err_clr_i(err_clr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int slot(input logic [31:0] a);
    return int'(a / 32'h1000_0000);
  endfunction
  task automatic model_comb();
    int rs, ws, ms;
    rs = slot(m0_rd_addr);
    ws = slot(m0_wr_addr);
    ms = slot(m1_addr);
    for (int k = 0; k < 4; k++) begin
      ea[k] = '0;
      ew[k] = '0;
      ewe[k] = 1'b0;
    end
    e_rd0 = '0;
    e_rd1 = '0;
    e_err = 1'b0;
    e_erra = '0;
    if (owner) begin
      if (m1_req && ms < 4) begin
        ea[ms] = m1_addr;
        ew[ms] = m1_wdata;
        ewe[ms] = m1_we && !rst;
        e_rd1 = sd[ms];
      end else if (m1_req) begin
        e_err = 1'b1;
        e_erra = m1_addr;
      end
    end else begin
      if (m0_rd_req && rs < 4 && !(m0_wr_req && ws == rs)) begin
        ea[rs] = m0_rd_addr;
        e_rd0 = sd[rs];
      end
      if (m0_wr_req && ws < 4) begin
        ea[ws] = m0_wr_addr;
        ew[ws] = m0_wr_data;
        ewe[ws] = m0_wr_en;
      end
      if (m0_rd_req && rs >= 4) begin
        e_err = 1'b1;
        e_erra = m0_rd_addr;
      end
      if (m0_wr_req && ws >= 4) begin
        e_err = 1'b1;
        e_erra = m0_wr_addr;
      end
    end
  endtask
  task automatic settle();
    model_comb();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s%0d_addr", k), sa[k], ea[k]);
      chk($sformatf("s%0d_wdata", k), sw[k], ew[k]);
      chk($sformatf("s%0d_we", k), {31'b0, swe[k]}, {31'b0, ewe[k]});
    end
    chk("m0_rd_data", m0_rd_data, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("hold", {31'b0, hold}, {31'b0, owner | m1_req});
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      owner = 1'b0;
      m_err = 1'b0;
      m_erra = '0;
    end else begin
      owner = m1_req;
      if (e_err) begin
        if (!m_err || err_clr) m_erra = e_erra;
        m_err = 1'b1;
      end else if (err_clr) m_err = 1'b0;
    end
    @(negedge clk);
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, owner});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("err_addr", err_addr, m_erra);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) sd[k] = 32'h1111_0000 * (k + 1);
    owner = 1'b0;
    m_err = 1'b0;
    m_erra = '0;
    @(negedge clk);
    settle();
    tick();
    chk("reset_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_erra", err_addr, 32'd0);
    rst = 1'b0;
    m0_rd_req = 1'b1; m0_rd_addr = 32'h1000_0010; sd[1] = 32'hDEAD_BEEF;
    settle();
    chk("core_rd", m0_rd_data, 32'hDEAD_BEEF);
    chk("core_rd_no_we", {31'b0, swe[1]}, 32'd0);
    tick();
    m0_rd_req = 1'b0; m1_req = 1'b1;
    m0_wr_req = 1'b1; m0_wr_en = 1'b1; m0_wr_addr = 32'h1000_0000; m0_wr_data = 32'h55;
    settle();
    chk("takeover_wr", {31'b0, swe[1]}, 32'd1);
    chk("takeover_hold", {31'b0, hold}, 32'd1);
    chk("takeover_gnt_n", {31'b0, m1_gnt}, 32'd0);
    tick();
    chk("takeover_gnt_n1", {31'b0, m1_gnt}, 32'd1);
    m1_we = 1'b1; m1_addr = 32'h3000_0004; m1_wdata = 32'h41;
    settle();
    chk("ld_wr_we", {31'b0, swe[3]}, 32'd1);
    chk("ld_wr_data", sw[3], 32'h41);
    chk("ld_core_blocked", {31'b0, swe[1]}, 32'd0);
    tick();
    m1_req = 1'b0; m1_we = 1'b0; m0_wr_req = 1'b0; m0_wr_en = 1'b0;
    settle();
    tick();
    chk("release_gnt", {31'b0, m1_gnt}, 32'd0);
    m0_rd_req = 1'b1; m0_rd_addr = 32'h1000_0010;
    settle();
    chk("release_hold", {31'b0, hold}, 32'd0);
    chk("release_rd", m0_rd_data, 32'hDEAD_BEEF);
    tick();
    m0_rd_addr = 32'h5000_0000;
    settle();
    chk("dec_rd0", m0_rd_data, 32'd0);
    tick();
    chk("dec_err", {31'b0, err}, 32'd1);
    chk("dec_erra", err_addr, 32'h5000_0000);
    m0_rd_addr = 32'h6000_0000;
    settle();
    tick();
    chk("dec_erra_hold", err_addr, 32'h5000_0000);
    err_clr = 1'b1;
    settle();
    tick();
    chk("clr_vs_err", {31'b0, err}, 32'd1);
    chk("clr_recapture", err_addr, 32'h6000_0000);
    m0_rd_req = 1'b0;
    settle();
    tick();
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_erra_kept", err_addr, 32'h6000_0000);
    err_clr = 1'b0;
    m0_rd_req = 1'b1; m0_rd_addr = 32'h1000_0020;
    m0_wr_req = 1'b1; m0_wr_en = 1'b1; m0_wr_addr = 32'h1000_0000;
    settle();
    chk("same_slave_addr", sa[1], 32'h1000_0000);
    chk("same_slave_rd", m0_rd_data, 32'd0);
    tick();
    m0_rd_req = 1'b0; m0_wr_req = 1'b0; m0_wr_en = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h7000_0000;
    settle();
    tick();
    settle();
    tick();
    chk("grant_err", {31'b0, err}, 32'd1);
    rst = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000_0000;
    settle();
    chk("rst_no_m1_wr", {31'b0, swe[2]}, 32'd0);
    tick();
    chk("rst_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    settle();
    chk("rst_hold", {31'b0, hold}, 32'd0);
    tick();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      m0_rd_req = 1'($urandom);
      m0_wr_req = 1'($urandom);
      m0_wr_en = 1'($urandom);
      m0_rd_addr = {1'b0, 3'($urandom), 28'($urandom)};
      m0_wr_addr = {1'b0, 3'($urandom), 28'($urandom)};
      m0_wr_data = $urandom;
      m1_req = ($urandom_range(0, 9) < 4);
      m1_we = 1'($urandom);
      m1_addr = {1'b0, 3'($urandom), 28'($urandom)};
      m1_wdata = $urandom;
      err_clr = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) sd[k] = $urandom;
      settle();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
